imem_reader: RTL and testbench
==============================

Name: imem_reader

Overview:
- Read-back engine for the byte-addressed instruction memory, the counterpart of the instruction load path (we_ins/load), which writes it.
- On a start command it fetches N consecutive 16-bit instructions, two bytes per instruction with PC stepping by 2, and assembles each word.
- It presents each word on a valid/ready stream for debug dump or program verification after load.
- It sits beside the instruction memory in top_level and shares the memory read port with fetch, which is idle while busy=1.

Parameters:
ADDR_W, 8, byte address width of instruction memory
CNT_W, 8, width of word_count

Ports:
clka  in  1  single system clock, rising-edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle command pulse; sampled only in IDLE
base_addr  in  ADDR_W  byte address of the first instruction; bit0 ignored, forced even
word_count  in  CNT_W  number of 16-bit instructions to read
mem_addr  out  ADDR_W  byte address to instruction memory
mem_rd_en  out  1  read strobe to instruction memory
mem_rdata  in  8  read data; valid exactly 1 cycle after mem_rd_en
out_word  out  16  assembled instruction, {byte[a], byte[a+1]} (big-endian)
out_valid  out  1  out_word is valid
out_ready  in  1  consumer accepts out_word
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at end of command

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; mem_addr=0, mem_rd_en=0, out_word=0, out_valid=0, busy=0, done=0; internal ptr and count cleared.
- Reset asserted mid-operation aborts immediately with no done pulse. After release, the block waits in IDLE for a new start.
- States: IDLE, RD_HI, RD_LO, CAP_LO, PRESENT, FIN.
- IDLE, start=1, word_count!=0: latch ptr={base_addr[ADDR_W-1:1],0}, count=word_count, busy<=1, go to RD_HI.
- IDLE, start=1, word_count==0: go to FIN; no memory reads.
- RD_HI: mem_rd_en=1, mem_addr=ptr; go to RD_LO.
- RD_LO: mem_rd_en=1, mem_addr=ptr+1; capture mem_rdata into out_word[15:8]; go to CAP_LO.
- CAP_LO: mem_rd_en=0; capture mem_rdata into out_word[7:0]; out_valid<=1; go to PRESENT.
- PRESENT: hold out_word and out_valid stable while out_ready=0.
- PRESENT, out_ready=1: handshake completes; out_valid<=0; ptr<=ptr+2; count<=count-1. Go to FIN if count==1, else RD_HI.
- FIN: done=1 for exactly one cycle; busy<=0; return to IDLE.
- mem_rd_en is 0 in IDLE, CAP_LO, PRESENT and FIN; mem_addr holds its last value there.
- Latency: start sampled at edge E0 gives out_valid=1 after E3. Minimum 4 cycles per word with out_ready tied high.
- Address arithmetic is modulo 2^ADDR_W. ptr+1 and ptr+2 wrap: 0xFE+1=0xFF, 0xFE+2=0x00. Words spanning the wrap are legal.
- start while busy=1 is ignored; latched parameters stay unchanged.
- out_ready while out_valid=0 has no effect.
- base_addr and word_count are sampled only on start acceptance; later changes are ignored.
- No word is dropped or duplicated; exactly word_count handshakes occur per command.

Test Plan:
- Memory bytes 0..5 = 10 28 12 61 92 40; start, base=0, count=3, out_ready=1 -> words 0x1028, 0x1261, 0x9240 in order; done pulse one cycle after the third handshake; busy low after.
- Same memory, out_ready held low 5 cycles on the 2nd word -> out_word stays 0x1261 with out_valid=1 throughout; no mem_rd_en until acceptance; total 3 handshakes.
- base=0xFE, count=2, mem[FE..01]=AA BB CC DD -> 0xAABB then 0xCCDD; mem_addr sequence FE, FF, 00, 01.
- start with count=0 -> no mem_rd_en; done pulses one cycle after start; busy stays low; out_valid never rises.
- start with base=0x03 -> reads begin at 0x02.
- start re-pulsed with base=0x20 during an active count=3 read at base=0 -> ignored; 3 words from 0x00 are returned.
- reset driven low during PRESENT of word 2 -> outputs zero immediately, asynchronously; no done. After release, start base=4, count=1 -> single word 0x9240, then done.

Source files
------------

// File: rtl/imem_reader.sv
// Purpose : reads N consecutive 16-bit big-endian instructions from byte-wide instruction memory and streams them out.
// Latency : start at edge E0 -> first out_valid after E3; at least 4 cycles per word when out_ready stays high.
// Backpres: out_word/out_valid hold in PRESENT until out_ready; no memory reads are issued while a word waits.
module imem_reader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_HI   = 3'd1,
    RD_LO   = 3'd2,
    CAP_LO  = 3'd3,
    PRESENT = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  count;

  // Instructions are 2-byte aligned, so the low address bit is always cleared.
  logic [ADDR_W-1:0] base_even;
  assign base_even = base_addr & ~ADDR_W'(1);

  // Command FSM; every output is registered and set on entry to the state that owns it.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      out_word  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              // Latch the command and issue the high-byte read straight away.
              ptr       <= base_even;
              count     <= word_count;
              busy      <= 1'b1;
              mem_addr  <= base_even;
              mem_rd_en <= 1'b1;
              state     <= RD_HI;
            end else begin
              // Empty command: report completion without touching memory.
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end

        RD_HI: begin
          // Low-byte read; address wraps modulo 2^ADDR_W.
          mem_addr  <= ptr + ADDR_W'(1);
          mem_rd_en <= 1'b1;
          state     <= RD_LO;
        end

        RD_LO: begin
          // Data for the high-byte read arrives now.
          out_word[15:8] <= mem_rdata;
          mem_rd_en      <= 1'b0;
          state          <= CAP_LO;
        end

        CAP_LO: begin
          out_word[7:0] <= mem_rdata;
          out_valid     <= 1'b1;
          state         <= PRESENT;
        end

        PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr       <= ptr + ADDR_W'(2);
            count     <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              // Next word: issue its high-byte read without an idle cycle.
              mem_addr  <= ptr + ADDR_W'(2);
              mem_rd_en <= 1'b1;
              state     <= RD_HI;
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          mem_rd_en <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_reader.sv
module tb_imem_reader;

  logic        clka;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  word_count;
  logic [7:0]  mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic [15:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  imem_reader #(.ADDR_W(8), .CNT_W(8)) dut (
    .clka(clka), .reset(reset), .start(start), .base_addr(base_addr),
    .word_count(word_count), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .out_word(out_word), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Synchronous-read byte memory: data valid one cycle after the strobe.
  logic [7:0] mem [256];
  always @(posedge clka) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model state: expected read addresses and words for the current command.
  logic [7:0]  exp_addr [$];
  logic [15:0] exp_word [$];
  logic [7:0]  got_addr [$];
  logic [15:0] got      [$];
  int          hs_cyc   [$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          done_base = 0;
  int          start_cyc = 0;
  bit          busy_seen = 0;
  bit          valid_seen = 0;
  bit          prev_hold = 0;
  bit          prev_done = 0;
  logic [15:0] prev_word = '0;

  // Compare process: every cycle, check reads, handshakes, hold stability, done width.
  always @(negedge clka) begin
    cyc++;
    if (reset) begin
      if (busy) busy_seen = 1;
      if (out_valid) valid_seen = 1;
      if (mem_rd_en) begin
        got_addr.push_back(mem_addr);
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual addr=%0h required=no read", mem_addr);
        end else chk("rd_addr", mem_addr, exp_addr.pop_front());
      end
      if (out_valid) chk("no_rd_while_valid", mem_rd_en, 1'b0);
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_word", out_word, prev_word);
      end
      if (out_valid && out_ready) begin
        got.push_back(out_word);
        hs_cyc.push_back(cyc);
        if (exp_word.size() == 0) begin
          checks++; errors++;
          $display("FAIL hs_unexpected actual word=%0h required=no handshake", out_word);
        end else chk("hs_word", out_word, exp_word.pop_front());
      end
      if (done) begin
        chk("done_width", prev_done, 1'b0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_hold = out_valid && !out_ready;
      prev_word = out_word;
      prev_done = done;
    end else begin
      prev_hold = 0;
      prev_done = 0;
    end
  end

  // Build the expected stream from the command, then pulse start for one cycle.
  task automatic launch(input logic [7:0] base, input logic [7:0] cnt);
    logic [7:0] a;
    a = base & 8'hFE;
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back(a);
      exp_addr.push_back(a + 8'd1);
      exp_word.push_back({mem[a], mem[a + 8'd1]});
      a = a + 8'd2;
    end
    got.delete(); got_addr.delete(); hs_cyc.delete();
    busy_seen = 0; valid_seen = 0;
    done_base = done_cnt;
    start = 1'b1; base_addr = base; word_count = cnt;
    start_cyc = cyc;
    @(posedge clka); #1;
    start = 1'b0; base_addr = 8'h55; word_count = 8'd7;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clka); #1; n++;
    end
    if (done_cnt == done_base) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=no done required=done within %0d cycles", budget);
    end
    @(posedge clka); #1;
    chk("busy_after_done", busy, 1'b0);
    chk("exp_addr_drained", exp_addr.size(), 0);
    chk("exp_word_drained", exp_word.size(), 0);
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 200) begin @(posedge clka); #1; k++; end
    if (got.size() < n) begin
      checks++; errors++;
      $display("FAIL got_timeout actual=%0d required=%0d words", got.size(), n);
    end
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    while (!out_valid && k < 50) begin @(posedge clka); #1; k++; end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL valid_timeout actual=0 required=1");
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 8'h00);
    chk({tag, "_mem_rd_en"}, mem_rd_en, 1'b0);
    chk({tag, "_out_word"}, out_word, 16'h0000);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    int dc;
    reset = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h10; mem[1] = 8'h28; mem[2] = 8'h12;
    mem[3] = 8'h61; mem[4] = 8'h92; mem[5] = 8'h40;
    repeat (2) @(posedge clka);
    #1;
    chk_zero("reset");
    reset = 1'b1;
    @(posedge clka); #1;

    // Three words back-to-back, latency and per-word spacing.
    launch(8'h00, 8'd3);
    @(posedge clka); @(posedge clka); #1;
    chk("lat_not_yet_valid_E2", out_valid, 1'b0);
    @(posedge clka); #1;
    chk("lat_valid_E3", out_valid, 1'b1);
    wait_done(100);
    chk("t1_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t1_w0", got[0], 16'h1028);
      chk("t1_w1", got[1], 16'h1261);
      chk("t1_w2", got[2], 16'h9240);
      chk("t1_spacing", hs_cyc[1] - hs_cyc[0], 4);
      chk("t1_done_time", done_cyc, hs_cyc[2] + 1);
    end

    // Backpressure on word 2 for 5 cycles.
    launch(8'h00, 8'd3);
    wait_got(1);
    out_ready = 1'b0;
    wait_valid();
    repeat (5) @(posedge clka);
    #1;
    chk("t2_still_valid", out_valid, 1'b1);
    chk("t2_held_word", out_word, 16'h1261);
    out_ready = 1'b1;
    wait_done(100);
    chk("t2_count", got.size(), 3);
    if (got.size() == 3) chk("t2_w1", got[1], 16'h1261);

    // Address wrap across 0xFF -> 0x00.
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[0] = 8'hCC; mem[1] = 8'hDD;
    launch(8'hFE, 8'd2);
    wait_done(100);
    chk("t3_count", got.size(), 2);
    chk("t3_rd_count", got_addr.size(), 4);
    if (got.size() == 2 && got_addr.size() == 4) begin
      chk("t3_w0", got[0], 16'hAABB);
      chk("t3_w1", got[1], 16'hCCDD);
      chk("t3_a0", got_addr[0], 8'hFE);
      chk("t3_a1", got_addr[1], 8'hFF);
      chk("t3_a2", got_addr[2], 8'h00);
      chk("t3_a3", got_addr[3], 8'h01);
    end
    mem[0] = 8'h10; mem[1] = 8'h28;

    // Zero-length command.
    launch(8'h10, 8'd0);
    wait_done(20);
    chk("t4_done_time", done_cyc, start_cyc + 2);
    chk("t4_busy_seen", busy_seen, 1'b0);
    chk("t4_valid_seen", valid_seen, 1'b0);
    chk("t4_no_reads", got_addr.size(), 0);

    // Odd base address is forced even.
    launch(8'h03, 8'd1);
    wait_done(50);
    chk("t5_count", got.size(), 1);
    if (got.size() == 1) chk("t5_w0", got[0], 16'h1261);
    if (got_addr.size() > 0) chk("t5_first_addr", got_addr[0], 8'h02);

    // Start while busy is ignored.
    launch(8'h00, 8'd3);
    @(posedge clka); #1;
    start = 1'b1; base_addr = 8'h20; word_count = 8'd5;
    @(posedge clka); #1;
    start = 1'b0;
    wait_done(100);
    chk("t6_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("t6_w0", got[0], 16'h1028);
      chk("t6_w2", got[2], 16'h9240);
    end

    // Asynchronous reset while word 2 is presented.
    launch(8'h00, 8'd3);
    wait_got(1);
    out_ready = 1'b0;
    wait_valid();
    #2 reset = 1'b0;
    #1;
    chk_zero("abort");
    exp_addr.delete(); exp_word.delete();
    dc = done_cnt;
    repeat (3) @(posedge clka);
    #1;
    chk("abort_no_done", done_cnt, dc);
    chk("abort_idle_busy", busy, 1'b0);
    reset = 1'b1; out_ready = 1'b1;
    @(posedge clka); #1;
    launch(8'h04, 8'd1);
    wait_done(50);
    chk("t7_count", got.size(), 1);
    if (got.size() == 1) chk("t7_w0", got[0], 16'h9240);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
